// File: rtl/uart_pkg.sv
// Shared UART types and helpers: parity modes, transmit FSM states,
// the minimum data-field width and the cfg_data_bits clamp.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } tx_state_e;

    localparam int MIN_DATA_BITS = 5;

    // Clamp a requested data-field width into [MIN_DATA_BITS, max_bits].
    function automatic logic [3:0] clamp_data_bits(input logic [3:0] cfg,
                                                   input logic [3:0] max_bits);
        if (cfg < 4'(MIN_DATA_BITS)) begin
            return 4'(MIN_DATA_BITS);
        end
        if (cfg > max_bits) begin
            return max_bits;
        end
        return cfg;
    endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational masked parity: XOR of the low nbits of data, inverted when
// odd parity is requested. Shared between the TX serializer and the RX checker.
module uart_parity_gen #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] data,
    input  logic [3:0]       nbits,
    input  logic             odd,
    output logic             parity
);

    logic [WIDTH-1:0] mask;

    // Build the field mask from nbits and reduce the masked word.
    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = (i < int'(nbits));
        end
        parity = (^(data & mask)) ^ odd;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames a word LSB-first as start, 5..MAX_DATA_BITS
// data bits, optional parity and 1 or 2 stop bits, paced by baud_tick.
// Optional feature: define UART_TX_BREAK_EN to add the break_req input and
// the BREAK state (line held at the active level while break_req is high).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = 9,
    parameter int IDLE_LEVEL    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     baud_tick,
    input  logic [3:0]               cfg_data_bits,
    input  logic [1:0]               cfg_parity,
    input  logic                     cfg_stop_bits,
    input  logic                     s_valid,
    input  logic [MAX_DATA_BITS-1:0] s_data,
    output logic                     s_ready,
    output logic                     tx,
    output logic                     tx_active,
    output logic                     tx_done,
    output logic                     parity_out
`ifdef UART_TX_BREAK_EN
    ,
    input  logic                     break_req
`endif
);

    localparam int   CNT_W    = $clog2(MAX_DATA_BITS + 1);
    localparam logic IDLE_BIT = (IDLE_LEVEL != 0);

    tx_state_e state_q, state_d;

    logic             tx_d;
    logic             tx_done_d;
    logic             active_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic             stop_last_q, stop_last_d;
    logic             brk_q, brk_d;

    // Frame parameters captured at accept; mid-frame cfg changes cannot reach them.
    logic [MAX_DATA_BITS-1:0] data_q;
    logic [CNT_W-1:0]         nbits_q;
    logic                     par_en_q;
    logic                     par_odd_q;
    logic                     two_stop_q;

    logic [3:0] nbits_clamped;
    logic       odd_par;
    logic       accept;
    logic       par_bit;

    assign nbits_clamped = clamp_data_bits(cfg_data_bits, 4'(MAX_DATA_BITS));

    // s_ready stays low through the tx_done cycle so a queued word waits one clock.
    assign s_ready = (state_q == IDLE) && !tx_done;
    assign accept  = s_valid && s_ready;

    // parity_out holds the odd-parity bit; even parity is simply its complement.
    assign par_bit = par_odd_q ? parity_out : ~parity_out;

    uart_parity_gen #(
        .WIDTH(MAX_DATA_BITS)
    ) u_parity_gen (
        .data  (s_data),
        .nbits (nbits_clamped),
        .odd   (1'b1),
        .parity(odd_par)
    );

    // Control state, line outputs and counters; reset aborts any frame silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tx          <= IDLE_BIT;
            tx_active   <= 1'b0;
            tx_done     <= 1'b0;
            bitcnt_q    <= '0;
            stop_last_q <= 1'b0;
            brk_q       <= 1'b0;
            parity_out  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx          <= tx_d;
            tx_active   <= active_d;
            tx_done     <= tx_done_d;
            bitcnt_q    <= bitcnt_d;
            stop_last_q <= stop_last_d;
            brk_q       <= brk_d;
            if (accept) begin
                parity_out <= odd_par;
            end
        end
    end

    // Latch the word and its framing options when the handshake completes.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q     <= s_data;
            nbits_q    <= nbits_clamped[CNT_W-1:0];
            par_en_q   <= (cfg_parity == PAR_ODD) || (cfg_parity == PAR_EVEN);
            par_odd_q  <= (cfg_parity == PAR_ODD);
            two_stop_q <= cfg_stop_bits;
        end
    end

    // Next-state and next-output logic; every bit boundary is a baud_tick.
    always_comb begin
        state_d     = state_q;
        tx_d        = tx;
        tx_done_d   = 1'b0;
        active_d    = tx_active;
        bitcnt_d    = bitcnt_q;
        stop_last_d = stop_last_q;
        brk_d       = brk_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = ARMED;
                    active_d = 1'b1;
                    brk_d    = 1'b0;
                end
`ifdef UART_TX_BREAK_EN
                else if (break_req && s_ready) begin
                    state_d  = BREAK;
                    tx_d     = ~IDLE_BIT;
                    active_d = 1'b1;
                    brk_d    = 1'b1;
                end
`endif
            end
            ARMED: begin
                if (baud_tick) begin
                    state_d = START;
                    tx_d    = ~IDLE_BIT;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d  = DATA;
                    tx_d     = data_q[0];
                    bitcnt_d = CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bitcnt_q == nbits_q) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d     = STOP;
                            tx_d        = IDLE_BIT;
                            stop_last_d = !two_stop_q;
                        end
                    end else begin
                        tx_d     = data_q[bitcnt_q];
                        bitcnt_d = bitcnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d     = STOP;
                    tx_d        = IDLE_BIT;
                    stop_last_d = !two_stop_q;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (!stop_last_q) begin
                        stop_last_d = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        tx_done_d   = !brk_q;
                        active_d    = 1'b0;
                        bitcnt_d    = '0;
                        stop_last_d = 1'b0;
                        brk_d       = 1'b0;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                if (baud_tick && !break_req) begin
                    state_d     = STOP;
                    tx_d        = IDLE_BIT;
                    stop_last_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer: directed frames plus randomized frames,
// each checked bit-by-bit against a frame model built from the framing rules.
// Define UART_TX_BREAK_EN to also exercise the break feature.
module tb_uart_tx_serializer;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic [3:0] cfg_data_bits;
    logic [1:0] cfg_parity;
    logic       cfg_stop_bits;
    logic       s_valid;
    logic [8:0] s_data;
    logic       s_ready;
    logic       tx;
    logic       tx_active;
    logic       tx_done;
    logic       parity_out;
`ifdef UART_TX_BREAK_EN
    logic       break_req;
`endif

    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    logic exp_bits [0:15];
    int   exp_len;
    logic exp_pout;

    uart_tx_serializer #(
        .MAX_DATA_BITS(9),
        .IDLE_LEVEL   (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick    (baud_tick),
        .cfg_data_bits(cfg_data_bits),
        .cfg_parity   (cfg_parity),
        .cfg_stop_bits(cfg_stop_bits),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .tx           (tx),
        .tx_active    (tx_active),
        .tx_done      (tx_done),
        .parity_out   (parity_out)
`ifdef UART_TX_BREAK_EN
        ,
        .break_req    (break_req)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clock baud tick every 4 clocks, changed on the falling edge.
    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    // Count tx_done pulses as seen by the rising edge.
    always @(posedge clk) begin
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Reference frame: start, clamped data LSB-first, optional parity, stop bits.
    task automatic build_model(input logic [8:0] d, input int nb_cfg, input int par, input int stop);
        int n;
        int ones;
        n    = (nb_cfg < 5) ? 5 : ((nb_cfg > 9) ? 9 : nb_cfg);
        ones = 0;
        exp_bits[0] = 1'b0;
        exp_len     = 1;
        for (int i = 0; i < n; i++) begin
            exp_bits[exp_len] = d[i];
            exp_len++;
            if (d[i]) ones++;
        end
        exp_pout = ((ones % 2) == 0);
        if (par == 1) begin
            exp_bits[exp_len] = ((ones % 2) == 0);
            exp_len++;
        end else if (par == 2) begin
            exp_bits[exp_len] = ((ones % 2) == 1);
            exp_len++;
        end
        for (int i = 0; i <= stop; i++) begin
            exp_bits[exp_len] = 1'b1;
            exp_len++;
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            if (baud_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_tick no baud tick within 16 clocks");
        end
    endtask

    // Wait for s_ready with s_valid already driven, then take the accept edge.
    task automatic do_accept(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s accept timeout s_ready never rose", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [8:0] d, input int nb, input int par, input int stop,
                               input string name, output bit ok);
        build_model(d, nb, par, stop);
        s_data        = d;
        cfg_data_bits = 4'(nb);
        cfg_parity    = 2'(par);
        cfg_stop_bits = 1'(stop);
        s_valid       = 1'b1;
        do_accept(name, ok);
    endtask

    // Called right after the accept edge: follows the frame one tick at a time.
    task automatic check_frame(input string name);
        int snap;
        bit ok;
        snap = done_cnt;
        checks++;
        if (parity_out !== exp_pout || tx_active !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s accept parity_out/tx_active/s_ready got %b%b%b want %b10",
                     name, parity_out, tx_active, s_ready, exp_pout);
        end
        wait_tick(ok);
        for (int k = 0; k < exp_len; k++) begin
            if (k > 0) wait_tick(ok);
            checks++;
            if (tx !== exp_bits[k] || tx_done !== 1'b0 || tx_active !== 1'b1 || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s bit %0d tx/done/active/ready got %b%b%b%b want %b010",
                         name, k, tx, tx_done, tx_active, s_ready, exp_bits[k]);
            end
        end
        wait_tick(ok);
        checks++;
        if (tx !== 1'b1 || tx_done !== 1'b1 || tx_active !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s end tx/done/active/ready got %b%b%b%b want 1100",
                     name, tx, tx_done, tx_active, s_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if ((done_cnt - snap) != 1 || tx_done !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after done_pulses=%0d tx_done=%b s_ready=%b want 1 0 1",
                     name, done_cnt - snap, tx_done, s_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0 || parity_out !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset tx/active/done/pout/ready got %b%b%b%b%b want 10001",
                     tx, tx_active, tx_done, parity_out, s_ready);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1 || s_ready !== 1'b1 || tx_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_release tx/ready/active got %b%b%b want 110", tx, s_ready, tx_active);
        end
    endtask

    task automatic test_8n1();
        bit ok;
        start_frame(9'h0A5, 8, 0, 0, "8n1", ok);
        s_valid = 1'b0;
        check_frame("8n1");
    endtask

    task automatic test_7o2();
        bit ok;
        start_frame(9'h155, 7, 1, 1, "7o2", ok);
        s_valid = 1'b0;
        check_frame("7o2");
    endtask

    task automatic test_clamp_parity();
        bit ok;
        start_frame(9'h1FF, 5, 2, 0, "5e1", ok);
        s_valid = 1'b0;
        check_frame("5e1");
        start_frame(9'h1FF, 9, 2, 0, "9e1", ok);
        s_valid = 1'b0;
        check_frame("9e1");
        start_frame(9'h1FF, 2, 2, 0, "clamp_lo", ok);
        s_valid = 1'b0;
        check_frame("clamp_lo");
        start_frame(9'h1FF, 15, 2, 0, "clamp_hi", ok);
        s_valid = 1'b0;
        check_frame("clamp_hi");
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int snap;
        start_frame(9'h05A, 8, 0, 0, "rst_mid", ok);
        s_valid = 1'b0;
        snap = done_cnt;
        repeat (5) wait_tick(ok);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1 || tx_active !== 1'b0 || s_ready !== 1'b1 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid tx/active/ready/done got %b%b%b%b want 1010",
                     tx, tx_active, s_ready, tx_done);
        end
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != snap || tx !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_quiet done_pulses=%0d tx=%b want 0 1", done_cnt - snap, tx);
        end
        start_frame(9'h03C, 8, 2, 0, "after_rst", ok);
        s_valid = 1'b0;
        check_frame("after_rst");
    endtask

    task automatic test_back_to_back();
        bit ok;
        start_frame(9'h001, 8, 0, 0, "b2b_1", ok);
        s_data        = 9'h080;
        cfg_data_bits = 4'd6;
        cfg_parity    = 2'b01;
        cfg_stop_bits = 1'b1;
        check_frame("b2b_1");
        start_frame(9'h080, 6, 1, 1, "b2b_2", ok);
        s_valid = 1'b0;
        check_frame("b2b_2");
    endtask

    task automatic test_random();
        bit ok;
        logic [8:0] d;
        int nb, par, stop;
        for (int f = 0; f < 14; f++) begin
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
            d    = 9'($urandom_range(0, 511));
            nb   = $urandom_range(0, 15);
            par  = $urandom_range(0, 3);
            stop = $urandom_range(0, 1);
            start_frame(d, nb, par, stop, "random", ok);
            s_valid = 1'b0;
            check_frame("random");
        end
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break();
        bit ok;
        bit all_low;
        int snap;
        snap = done_cnt;
        break_req = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b0 || s_ready !== 1'b0 || tx_active !== 1'b1) begin
            errors++;
            $display("FAIL break_enter tx/ready/active got %b%b%b want 001", tx, s_ready, tx_active);
        end
        all_low = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b0) all_low = 1'b0;
        end
        checks++;
        if (!all_low) begin
            errors++;
            $display("FAIL break_hold tx rose while break_req high got 0 want 1");
        end
        break_req = 1'b0;
        wait_tick(ok);
        checks++;
        if (tx !== 1'b1 || tx_active !== 1'b1 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL break_stop tx/active/done got %b%b%b want 110", tx, tx_active, tx_done);
        end
        wait_tick(ok);
        @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1 || tx_active !== 1'b0 || s_ready !== 1'b1 || done_cnt != snap) begin
            errors++;
            $display("FAIL break_end tx/active/ready got %b%b%b pulses %0d want 101 0",
                     tx, tx_active, s_ready, done_cnt - snap);
        end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        s_valid       = 1'b0;
        s_data        = '0;
        cfg_data_bits = 4'd8;
        cfg_parity    = 2'b00;
        cfg_stop_bits = 1'b0;
`ifdef UART_TX_BREAK_EN
        break_req     = 1'b0;
`endif
        test_reset();
        test_8n1();
        test_7o2();
        test_clamp_parity();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
